example_driver: RTL and testbench
=================================

EXAMPLE_DRIVER -- requirements
Module: example_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width; all data ports below are WIDTH bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
REQ-005 SHALL have port num_pairs  input  8  operand pairs per run; latched on accepted start.
REQ-006 SHALL have port mode  input  1  0 = counting operands, 1 = LFSR operands; latched on start.
REQ-007 SHALL have port gap  input  1  1 = insert one idle cycle after every issued pair; latched on start.
REQ-008 SHALL have port skew  input  1  1 = drive a_valid high on idle cycles (one-sided valid); latched on start.
REQ-009 SHALL have port seed  input  16  LFSR seed; latched on start.
REQ-010 SHALL have ports a_valid, b_valid  output  1  operand valids to the adder/subtractor block.
REQ-011 SHALL have ports a, b  output  WIDTH  operands.
REQ-012 SHALL have ports o1, o2  input  WIDTH  registered sum and difference returned by the adder/subtractor block.
REQ-013 SHALL have ports busy, done  output  1  run in progress / run finished (done held until the next accepted start).
REQ-014 SHALL have ports pass_count, err_count  output  8  checked cycles that matched / mismatched.
REQ-015 SHALL have port first_err  output  8  index of the first mismatching check; 8'hFF if none.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, GAP, DRAIN, DONE.
REQ-017 SHALL move IDLE/DONE -> ISSUE on start when num_pairs != 0, and IDLE/DONE -> DONE on start when num_pairs == 0, clearing the counters to 0 and first_err to 8'hFF, with done low for one cycle.
REQ-018 SHALL, in ISSUE, drive a_valid = b_valid = 1 with pair k (k = 0 .. num_pairs-1), then go to GAP if gap=1, else stay in ISSUE; after pair num_pairs-1 go to DRAIN.
REQ-019 SHALL, in GAP, drive b_valid = 0, a_valid = skew, a/b = next pair's operands, then return to ISSUE.
REQ-020 SHALL compute counting-mode operands as a = k, b = (2^WIDTH - 1) - k, both truncated to WIDTH bits.
REQ-021 SHALL compute LFSR-mode operands from a 16-bit Galois LFSR (taps 16'hB400), loaded with seed (16'hACE1 if seed == 0), with a = lfsr[15:8] and b = lfsr[7:0] (zero-extended or truncated to WIDTH), advancing once per issued pair only.
REQ-022 SHALL register the expected results for every driven cycle (ISSUE: a+b, a-b modulo 2^WIDTH; GAP: 0, 0) and compare them with o1/o2 exactly one cycle later.
REQ-023 SHALL count each comparison into pass_count or err_count, both saturating at 255.
REQ-024 SHALL, on the first mismatch of a run, load first_err with the check index (the count of prior checks, saturated to 8'hFE).
REQ-025 SHALL spend exactly one cycle in DRAIN (driving both valids 0, no new expected entry), performing the final check, then enter DONE.
REQ-026 SHALL drive busy = 1 in ISSUE, GAP and DRAIN only, and ignore start while busy.
REQ-027 SHALL drive a_valid = b_valid = 0 and a = b = 0 in IDLE and DONE.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-run, go to IDLE immediately, with all outputs 0 except first_err = 8'hFF, and discard pending checks.
REQ-029 SHALL resume normal behaviour on the first rising clk edge after rst_n deasserts, with no check performed for that edge.

Verification
REQ-030 Bench SHALL cover: mode=0, gap=0, num_pairs=3 -> a/b = 0/255, 1/254, 2/253 on consecutive cycles; o1 = 255 each; o2 = 1, 3, 5; pass_count = 3, err_count = 0, first_err = 8'hFF; done 5 cycles after start.
REQ-031 Bench SHALL cover: mode=0, gap=1, skew=1, num_pairs=2 -> the idle cycle shows a_valid = 1, b_valid = 0, and the expected o1 = o2 = 0; pass_count = 4.
REQ-032 Bench SHALL cover: a fault model forcing o1 bit 0 on the 2nd check of a 4-pair run -> err_count = 1, pass_count = 3, first_err = 1.
REQ-033 Bench SHALL cover: num_pairs = 0 -> DONE the next cycle, busy never high, counts 0.
REQ-034 Bench SHALL cover: rst_n pulsed low during ISSUE of a 10-pair run -> busy = 0 and valids = 0 asynchronously; a new start gives a clean 10/0 result.
REQ-035 Bench SHALL cover: mode=1, seed = 0 versus seed = 16'hACE1 -> identical operand sequences; a start pulse while busy leaves the run unchanged.

Source files
------------

// File: rtl/example_driver_if.sv
// Operand bus between the stimulus driver and the adder/subtractor block.
// The driver issues operands with per-side valids; the adder returns
// registered sum (o1) and difference (o2) one cycle later.
interface example_driver_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic             b_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] o1;
   logic [WIDTH-1:0] o2;

   modport master (output a_valid, b_valid, a, b, input o1, o2);
   modport slave  (input a_valid, b_valid, a, b, output o1, o2);
endinterface

// File: rtl/example_driver.sv
// Self-checking stimulus driver for an adder/subtractor block.
// Issues num_pairs operand pairs (counting or LFSR pattern), optionally
// separated by idle cycles, and checks the returned sum/difference one
// cycle after each driven cycle, keeping pass/error counts and the index
// of the first mismatch.
module example_driver #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        num_pairs,
   input  logic              mode,
   input  logic              gap,
   input  logic              skew,
   input  logic [15:0]       seed,
   example_driver_if.master  bus,
   output logic              busy,
   output logic              done,
   output logic [7:0]        pass_count,
   output logic [7:0]        err_count,
   output logic [7:0]        first_err
);

   typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       k_q;
   logic [7:0]       np_q;
   logic             mode_q, gap_q, skew_q;
   logic [15:0]      lfsr_q;
   logic             zero_run_q;
   logic [WIDTH-1:0] op_a, op_b;
   logic             accept;
   logic             exp_vld_d;
   logic [WIDTH-1:0] exp_o1_d, exp_o2_d;
   logic             chk_vld_p1;
   logic [WIDTH-1:0] exp_o1_p1, exp_o2_p1;
   logic             mismatch;
   logic [7:0]       pass_q, err_q, first_err_q, chk_idx_q;

   // Zero-extend or truncate an 8-bit value to the operand width.
   function automatic logic [WIDTH-1:0] fit_w(input logic [7:0] v);
      logic [WIDTH+7:0] t;
      t = {{WIDTH{1'b0}}, v};
      return t[WIDTH-1:0];
   endfunction

   // One step of the right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] r;
      r = {1'b0, v[15:1]};
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Check index tops out one below the "no error" marker.
   function automatic logic [7:0] sat_idx(input logic [7:0] v);
      return (v == 8'hFE) ? v : v + 8'd1;
   endfunction

   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign op_a     = mode_q ? fit_w(lfsr_q[15:8]) : fit_w(k_q);
   assign op_b     = mode_q ? fit_w(lfsr_q[7:0])  : ~fit_w(k_q);
   assign mismatch = (bus.o1 != exp_o1_p1) || (bus.o2 != exp_o2_p1);

   assign busy       = (state_q == ISSUE) || (state_q == GAP) || (state_q == DRAIN);
   assign done       = (state_q == DONE) && !zero_run_q;
   assign pass_count = pass_q;
   assign err_count  = err_q;
   assign first_err  = first_err_q;

   // Next state, operand bus and the expected result for this cycle.
   always_comb begin
      state_d     = state_q;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.a       = '0;
      bus.b       = '0;
      exp_vld_d   = 1'b0;
      exp_o1_d    = '0;
      exp_o2_d    = '0;
      case (state_q)
         IDLE, DONE: begin
            if (start) state_d = (num_pairs != 8'd0) ? ISSUE : DONE;
         end
         ISSUE: begin
            bus.a_valid = 1'b1;
            bus.b_valid = 1'b1;
            bus.a       = op_a;
            bus.b       = op_b;
            exp_vld_d   = 1'b1;
            exp_o1_d    = op_a + op_b;
            exp_o2_d    = op_a - op_b;
            if (gap_q)                         state_d = GAP;
            else if (k_q + 8'd1 == np_q)       state_d = DRAIN;
         end
         GAP: begin
            bus.a_valid = skew_q;
            bus.a       = op_a;
            bus.b       = op_b;
            exp_vld_d   = 1'b1;
            state_d     = (k_q == np_q) ? DRAIN : ISSUE;
         end
         DRAIN: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state: FSM, pair index, pending-check flag and result counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= 8'd0;
         zero_run_q  <= 1'b0;
         chk_vld_p1  <= 1'b0;
         pass_q      <= 8'd0;
         err_q       <= 8'd0;
         first_err_q <= 8'hFF;
         chk_idx_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         zero_run_q <= accept && (num_pairs == 8'd0);
         chk_vld_p1 <= exp_vld_d;
         if (accept) begin
            k_q         <= 8'd0;
            pass_q      <= 8'd0;
            err_q       <= 8'd0;
            first_err_q <= 8'hFF;
            chk_idx_q   <= 8'd0;
         end else begin
            if (state_q == ISSUE) k_q <= k_q + 8'd1;
            if (chk_vld_p1) begin
               chk_idx_q <= sat_idx(chk_idx_q);
               if (mismatch) begin
                  err_q <= sat_inc(err_q);
                  if (err_q == 8'd0) first_err_q <= chk_idx_q;
               end else begin
                  pass_q <= sat_inc(pass_q);
               end
            end
         end
      end
   end

   // Run configuration, LFSR and expected-result pipeline (gated by control).
   always_ff @(posedge clk) begin
      if (accept) begin
         np_q   <= num_pairs;
         mode_q <= mode;
         gap_q  <= gap;
         skew_q <= skew;
         lfsr_q <= (seed == 16'd0) ? 16'hACE1 : seed;
      end else if (state_q == ISSUE) begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
      exp_o1_p1 <= exp_o1_d;
      exp_o2_p1 <= exp_o2_d;
   end

endmodule

// File: tb/tb_example_driver.sv
// Bench for example_driver: a behavioural adder/subtractor with an optional
// single-bit fault, a scoreboard of expected operand pairs, and a table of
// runs with expected counts and latencies, plus a mid-run reset sequence.
module tb_example_driver;
   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_pairs = 8'd0;
   logic        mode = 1'b0;
   logic        gap = 1'b0;
   logic        skew = 1'b0;
   logic [15:0] seed = 16'd0;
   logic        busy, done;
   logic [7:0]  pass_count, err_count, first_err;

   logic        fault_en = 1'b0;
   int          beat = 0;
   int          nvec = 0;
   int          nerr = 0;
   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   logic [7:0]  ea, eb;

   typedef struct packed {
      logic [7:0]  np;
      logic        m;
      logic        g;
      logic        s;
      logic [15:0] sd;
      logic        flt;
      logic        poke;
      int          exp_pass;
      int          exp_err;
      int          exp_fe;
      int          exp_cyc;
   } vec_t;

   vec_t tbl [0:9];

   example_driver_if #(.WIDTH(WIDTH)) bus();

   example_driver #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_pairs  (num_pairs),
      .mode       (mode),
      .gap        (gap),
      .skew       (skew),
      .seed       (seed),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .pass_count (pass_count),
      .err_count  (err_count),
      .first_err  (first_err)
   );

   always #5 clk = ~clk;

   // Adder/subtractor model; the fault flips o1 bit 0 on the 2nd pair of a run.
   always @(posedge clk) begin
      if (bus.a_valid && bus.b_valid) begin
         bus.o1 <= (bus.a + bus.b) ^ {7'd0, (fault_en && beat == 1)};
         bus.o2 <= bus.a - bus.b;
      end else begin
         bus.o1 <= '0;
         bus.o2 <= '0;
      end
      if (start) beat <= 0;
      else if (bus.a_valid && bus.b_valid) beat <= beat + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic push_pairs(input logic [7:0] np, input logic m, input logic [15:0] sd);
      logic [15:0] l;
      logic [7:0]  kk;
      l = (sd == 16'd0) ? 16'hACE1 : sd;
      for (int k = 0; k < np; k++) begin
         kk = k[7:0];
         if (m) begin
            qa.push_back(l[15:8]);
            qb.push_back(l[7:0]);
            l = lfsr_next(l);
         end else begin
            qa.push_back(kk);
            qb.push_back(8'd255 - kk);
         end
      end
   endtask

   // Scoreboard: every issued pair is compared against the next queued one.
   always @(negedge clk) begin
      if (bus.a_valid && bus.b_valid) begin
         if (qa.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_pair: got a=%0d b=%0d, expected no pair", bus.a, bus.b);
         end else begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            check("op_a", int'(bus.a), int'(ea));
            check("op_b", int'(bus.b), int'(eb));
         end
      end
   end

   task automatic run(input vec_t v);
      int cyc;
      fault_en = v.flt;
      push_pairs(v.np, v.m, v.sd);
      @(negedge clk);
      num_pairs = v.np;
      mode      = v.m;
      gap       = v.g;
      skew      = v.s;
      seed      = v.sd;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      check("busy_after_start", int'(busy), int'(v.np != 8'd0));
      check("done_low_after_start", int'(done), 0);
      while (!done && cyc < 1000) begin
         if (v.poke && cyc == 2) begin
            start     = 1'b1;
            num_pairs = 8'd1;
            mode      = ~v.m;
            gap       = ~v.g;
         end
         if (v.poke && cyc == 3) begin
            start     = 1'b0;
            num_pairs = v.np;
            mode      = v.m;
            gap       = v.g;
         end
         if (v.g && cyc == 2) begin
            check("gap_a_valid", int'(bus.a_valid), int'(v.s));
            check("gap_b_valid", int'(bus.b_valid), 0);
            if (qa.size() > 0) check("gap_next_a", int'(bus.a), int'(qa[0]));
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("done", int'(done), 1);
      check("cycles_to_done", cyc, v.exp_cyc);
      check("pass_count", int'(pass_count), v.exp_pass);
      check("err_count", int'(err_count), v.exp_err);
      check("first_err", int'(first_err), v.exp_fe);
      check("busy_in_done", int'(busy), 0);
      check("a_valid_in_done", int'(bus.a_valid), 0);
      check("a_in_done", int'(bus.a), 0);
      check("b_in_done", int'(bus.b), 0);
      check("pairs_left", qa.size(), 0);
      qa.delete();
      qb.delete();
      fault_en = 1'b0;
   endtask

   initial begin
      //            np      m     g     s     seed       flt   poke  pass err  fe   cyc
      tbl[0] = '{8'd3,   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3,   0,   255, 5};
      tbl[1] = '{8'd2,   1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 4,   0,   255, 6};
      tbl[2] = '{8'd4,   1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3,   1,   1,   6};
      tbl[3] = '{8'd0,   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0,   0,   255, 2};
      tbl[4] = '{8'd6,   1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6,   0,   255, 8};
      tbl[5] = '{8'd6,   1'b1, 1'b0, 1'b0, 16'hACE1, 1'b0, 1'b0, 6,   0,   255, 8};
      tbl[6] = '{8'd5,   1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 5,   0,   255, 7};
      tbl[7] = '{8'd3,   1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 6,   0,   255, 8};
      tbl[8] = '{8'd200, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 255, 0,   255, 402};
      tbl[9] = '{8'd10,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10,  0,   255, 12};

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_a_valid", int'(bus.a_valid), 0);
      check("rst_pass", int'(pass_count), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_first_err", int'(first_err), 255);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      for (int i = 0; i < 9; i++) begin
         run(tbl[i]);
         @(posedge clk);
      end

      // Reset in the middle of a 10-pair run, then a clean rerun.
      push_pairs(8'd10, 1'b0, 16'd0);
      @(negedge clk);
      num_pairs = 8'd10;
      mode      = 1'b0;
      gap       = 1'b0;
      skew      = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("busy_before_reset", int'(busy), 1);
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      #1;
      check("midrun_rst_busy", int'(busy), 0);
      check("midrun_rst_a_valid", int'(bus.a_valid), 0);
      check("midrun_rst_b_valid", int'(bus.b_valid), 0);
      check("midrun_rst_pass", int'(pass_count), 0);
      check("midrun_rst_first_err", int'(first_err), 255);
      check("midrun_rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      run(tbl[9]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
